// File: rtl/pc_fetch_seq_if.sv
// Bus between the fetch sequencer and its datapath neighbours:
// the next-address mux, the decoder, instruction memory and the IR.
//
// Handshake: mem_req is the request and mem_ack is the response. mem_req is
// high for every cycle the sequencer sits in FETCH with pc stable. The
// transfer completes on the first rising edge where both are high. ir_load
// marks that cycle. mem_ack has no meaning while mem_req is low.
interface pc_fetch_seq_if;
    logic [3:0] next_addr;
    logic       halt;
    logic       mem_ack;
    logic [3:0] pc;
    logic [3:0] incre_output;
    logic       mem_req;
    logic       ir_load;
    logic       exec_en;
    logic [1:0] state;
    logic       fetch_err;

    // Environment side: drives next address, halt and memory ack.
    modport master (
        output next_addr, halt, mem_ack,
        input  pc, incre_output, mem_req, ir_load, exec_en, state, fetch_err
    );

    // Sequencer side.
    modport slave (
        input  next_addr, halt, mem_ack,
        output pc, incre_output, mem_req, ir_load, exec_en, state, fetch_err
    );
endinterface

// File: rtl/pc_fetch_seq.sv
// Program counter and fetch/decode/execute sequencer.
// Each instruction passes through FETCH (wait for memory), DECODE and
// EXECUTE. A FETCH cycle with no ack advances a wait counter. If no ack
// arrives within TIMEOUT FETCH cycles, the sequencer parks in HALT with a
// sticky error flag. Only reset leaves HALT.
// The legal range for TIMEOUT is 2..16. The 4-bit counter holds TIMEOUT-1.
module pc_fetch_seq #(
    parameter int TIMEOUT = 8
) (
    input logic           clk,
    input logic           rst,
    pc_fetch_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_DECODE  = 2'b01,
        S_EXECUTE = 2'b10,
        S_HALT    = 2'b11
    } state_t;

    // The timeout fires when the counter reaches this value and mem_ack is
    // still low. That FETCH cycle is the TIMEOUT-th one without an ack.
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] wait_q, wait_d;
    logic       err_q, err_d;

    // Next-state logic. An ack in the last FETCH cycle takes priority over
    // the timeout. next_addr and halt are used only in EXECUTE.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wait_d  = wait_q;
        err_d   = err_q;
        unique case (state_q)
            S_FETCH: begin
                if (bus.mem_ack) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (bus.halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = bus.next_addr;
                    wait_d  = 4'd0;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers. Reset is asynchronous, so reset aborts any
    // instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= 4'd0;
            wait_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded from the registered state. The one exception is
    // ir_load, which also follows mem_ack in the same cycle.
    assign bus.pc           = pc_q;
    assign bus.incre_output = pc_q + 4'd1;
    assign bus.mem_req      = (state_q == S_FETCH);
    assign bus.ir_load      = (state_q == S_FETCH) && bus.mem_ack;
    assign bus.exec_en      = (state_q == S_EXECUTE);
    assign bus.state        = state_q;
    assign bus.fetch_err    = err_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq. Stimulus is issued one instruction at a time.
// The memory ack delay, the EXECUTE next_addr and halt are random.
// next_addr, halt and mem_ack are randomised in every other cycle.
// The bench predicts each instruction's timeline from the rules:
//   - ack after d idle FETCH cycles, then DECODE and EXECUTE;
//   - a timeout after TIMEOUT idle cycles;
//   - the pc change at the end of EXECUTE.
module tb_pc_fetch_seq;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_fetch_seq_if bus();

    pc_fetch_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: expected pc, halted flag, sticky error flag.
    logic [3:0] exp_pc;
    logic       exp_halted;
    logic       exp_err;
    // Scoreboard of fetch addresses; popped when the memory transfer happens.
    logic [3:0] exp_q[$];

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for a cycle in state st.
    task automatic chk_cycle(input string tag, input logic [1:0] st, input logic ex_ir);
        chk({tag, ".state"},     {2'b00, bus.state}, {2'b00, st});
        chk({tag, ".mem_req"},   {3'b000, bus.mem_req}, {3'b000, st == 2'b00});
        chk({tag, ".ir_load"},   {3'b000, bus.ir_load}, {3'b000, ex_ir});
        chk({tag, ".exec_en"},   {3'b000, bus.exec_en}, {3'b000, st == 2'b10});
        chk({tag, ".pc"},        bus.pc, exp_pc);
        chk({tag, ".incre"},     bus.incre_output, 4'((exp_pc + 5'd1) % 16));
        chk({tag, ".fetch_err"}, {3'b000, bus.fetch_err}, {3'b000, exp_err});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        bus.next_addr = 4'($urandom_range(0, 15));
        bus.halt      = 1'($urandom_range(0, 1));
        bus.mem_ack   = 1'($urandom_range(0, 1));
    endtask

    // One instruction. The ack comes after d idle FETCH cycles;
    // d >= TIMEOUT means no ack arrives. na and h are applied in EXECUTE.
    task automatic run_instr(input int d, input logic [3:0] na, input logic h);
        logic [3:0] fetched;
        exp_q.push_back(exp_pc);
        for (int i = 0; i < TIMEOUT; i++) begin
            rand_inputs();
            bus.mem_ack = (i == d);
            #1 chk_cycle("fetch", 2'b00, i == d);
            if (i == d) begin
                fetched = exp_q.pop_front();
                chk("fetch_addr", bus.pc, fetched);
            end
            step();
            if (i == d) break;
        end
        if (d >= TIMEOUT) begin
            void'(exp_q.pop_front());
            exp_halted = 1'b1;
            exp_err    = 1'b1;
            #1 chk_cycle("timeout", 2'b11, 1'b0);
            return;
        end
        rand_inputs();
        #1 chk_cycle("decode", 2'b01, 1'b0);
        step();
        rand_inputs();
        bus.next_addr = na;
        bus.halt      = h;
        #1 chk_cycle("execute", 2'b10, 1'b0);
        step();
        if (h) exp_halted = 1'b1;
        else   exp_pc     = na;
    endtask

    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            #1 chk_cycle("halt", 2'b11, 1'b0);
            step();
        end
    endtask

    // Raise rst between clock edges and check the outputs before any edge.
    // Then release rst away from the rising edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        exp_pc     = 4'd0;
        exp_halted = 1'b0;
        exp_err    = 1'b0;
        exp_q.delete();
        chk_cycle("rst_async", 2'b00, bus.mem_ack);
        @(posedge clk);
        #1 chk_cycle("rst_held", 2'b00, bus.mem_ack);
        #2 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.next_addr = 4'd0;
        bus.halt      = 1'b0;
        bus.mem_ack   = 1'b0;
        exp_pc        = 4'd0;
        exp_halted    = 1'b0;
        exp_err       = 1'b0;
        #2 chk_cycle("rst_init", 2'b00, 1'b0);
        bus.mem_ack = 1'b1;
        #1 chk_cycle("rst_init_ack", 2'b00, 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;

        // Ack in the first FETCH cycle, increment path: pc advances every
        // 3 cycles.
        for (int k = 0; k < 5; k++) run_instr(0, 4'(exp_pc + 4'd1), 1'b0);

        // The pc wraps from 15 to 0.
        run_instr(0, 4'd15, 1'b0);
        run_instr(1, 4'(exp_pc + 4'd1), 1'b0);
        chk("wrap_pc", bus.pc, 4'd0);

        // Jump from 3 to 9. next_addr changes outside EXECUTE are ignored.
        run_instr(0, 4'd3, 1'b0);
        run_instr(2, 4'd9, 1'b0);
        chk("jump_pc", bus.pc, 4'd9);

        // The ack arrives in the last cycle before the timeout and wins.
        run_instr(TIMEOUT - 1, 4'd4, 1'b0);
        chk("late_ack_err", {3'b000, bus.fetch_err}, 4'd0);

        // Random ack delays and addresses within the timeout.
        for (int k = 0; k < 30; k++)
            run_instr($urandom_range(0, TIMEOUT - 1), 4'($urandom_range(0, 15)), 1'b0);

        // Halt at pc=5. HALT holds for 20 cycles, then reset.
        run_instr(0, 4'd5, 1'b0);
        run_instr(0, 4'd12, 1'b1);
        hold_halt(20);
        do_reset();

        // Fetch timeout: error flag set, then reset while in HALT.
        run_instr(0, 4'd7, 1'b0);
        run_instr(TIMEOUT, 4'd0, 1'b0);
        hold_halt(5);
        do_reset();

        // Reset raised while in DECODE.
        exp_q.push_back(exp_pc);
        rand_inputs();
        bus.mem_ack = 1'b1;
        #1 chk_cycle("pre_decode", 2'b00, 1'b1);
        void'(exp_q.pop_front());
        step();
        rand_inputs();
        #1 chk_cycle("decode_rst", 2'b01, 1'b0);
        do_reset();

        // Random mix of acks, timeouts, halts and resets.
        for (int k = 0; k < 40; k++) begin
            run_instr($urandom_range(0, TIMEOUT + 1), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 7) == 0));
            if (exp_halted) begin
                hold_halt($urandom_range(1, 4));
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_fetch_seq.md
PC_FETCH_SEQ -- requirements
Module: pc_fetch_seq

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter TIMEOUT, default 8, SHALL set the maximum number of FETCH cycles without mem_ack before fault; legal range 2..16.
REQ-003 Port clk, input, 1: system clock, all state updates on rising edge.
REQ-004 Port rst, input, 1: asynchronous active-high reset.
REQ-005 Port next_addr, input, 4: next-instruction address from the jump/increment select mux.
REQ-006 Port halt, input, 1: halt request from decoder, sampled in EXECUTE only.
REQ-007 Port mem_ack, input, 1: instruction memory has valid data for the address on pc.
REQ-008 Port pc, output, 4: current program counter, registered; instruction memory address.
REQ-009 Port incre_output, output, 4: pc + 1 modulo 16, combinational; feeds the mux increment input.
REQ-010 Port mem_req, output, 1: fetch request, high exactly while in FETCH.
REQ-011 Port ir_load, output, 1: instruction register load strobe.
REQ-012 Port exec_en, output, 1: execute-stage enable, high exactly while in EXECUTE.
REQ-013 Port state, output, 2: FSM state; FETCH=00, DECODE=01, EXECUTE=10, HALT=11.
REQ-014 Port fetch_err, output, 1: sticky fetch-timeout flag.

Function
REQ-015 The FSM SHALL sequence FETCH -> DECODE -> EXECUTE -> FETCH, one instruction per pass.
REQ-016 FETCH SHALL persist until mem_ack; the cycle mem_ack is high, ir_load SHALL be high (combinational: state==FETCH and mem_ack) and the next state SHALL be DECODE.
REQ-017 ir_load SHALL never be high outside FETCH, regardless of mem_ack.
REQ-018 DECODE SHALL last exactly one cycle, then EXECUTE.
REQ-019 EXECUTE SHALL last exactly one cycle; with halt=0, pc SHALL load next_addr at the closing edge and the next state SHALL be FETCH.
REQ-020 EXECUTE with halt=1 SHALL leave pc unchanged and go to HALT.
REQ-021 HALT SHALL be absorbing: pc held, mem_req/ir_load/exec_en low, exit only via rst.
REQ-022 A 4-bit wait counter SHALL clear on every entry to FETCH and increment each FETCH cycle with mem_ack low.
REQ-023 If mem_ack stays low for TIMEOUT consecutive FETCH cycles, the FSM SHALL enter HALT and set fetch_err at that edge.
REQ-024 If mem_ack rises in the same cycle the timeout would fire, the ack SHALL win: DECODE, no fault.
REQ-025 incre_output SHALL wrap 15 -> 0; pc SHALL load next_addr exactly, so 15 -> 0 is a normal transition.
REQ-026 next_addr SHALL be ignored in every state except EXECUTE.
REQ-027 Minimum instruction period SHALL be 3 cycles (ack in first FETCH cycle).

Reset
REQ-028 While rst is high, independent of clk: pc=0, state=FETCH, wait counter=0, fetch_err=0.
REQ-029 Output values under reset: mem_req=1 (state FETCH), ir_load=mem_ack, exec_en=0, incre_output=1.
REQ-030 rst asserted mid-instruction (any state, including HALT) SHALL abort it with no pc update; first post-reset fetch SHALL be at address 0.

Verification
REQ-031 Reset release, mem_ack tied high, next_addr=incre_output -> pc steps 0,1,2,... every 3 cycles; ir_load one cycle per pass; exec_en one cycle per pass.
REQ-032 pc=15, EXECUTE with next_addr=incre_output=0 -> pc=0, state FETCH, no fault.
REQ-033 In EXECUTE at pc=3, next_addr=9 (jump) -> next fetch address 9; next_addr changes in FETCH/DECODE have no effect.
REQ-034 TIMEOUT=8, mem_ack low 8 FETCH cycles -> state=11, fetch_err=1, mem_req=0; ack on the 8th cycle instead -> DECODE, fetch_err=0.
REQ-035 halt=1 in EXECUTE at pc=5 -> state=HALT, pc stays 5 for 20 cycles despite mem_ack/next_addr toggling; rst -> pc=0, FETCH.
REQ-036 rst pulsed asynchronously (between edges) during DECODE -> outputs reach reset values without a clock edge; fetch_err clears.
